// File: rtl/gray_counter_if.sv
// rtl/gray_counter_if.sv - control and count bus of the Gray-code counter
//
// Purpose: groups the count controls and the registered count outputs.
// Signals:
//   en        master->slave  count enable
//   up        master->slave  direction, 1 = increment
//   load      master->slave  parallel load strobe
//   load_bin  master->slave  binary value to load
//   gray      slave->master  registered Gray-code count
//   bin       slave->master  registered binary count
//   term      slave->master  range end reached on the previous step
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] gray;
   logic [WIDTH-1:0] bin;
   logic             term;

   modport master (
      output en, up, load, load_bin,
      input  gray, bin, term
   );

   modport slave (
      input  en, up, load, load_bin,
      output gray, bin, term
   );
endinterface

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down counter with registered Gray and binary outputs
//
// Purpose: binary up/down counter with parallel load, wrap or saturate at the
// range ends, and a one-cycle terminal flag. The Gray code is derived from the
// next binary value and registered on the same edge, so gray and bin always
// move together and gray never glitches.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; clears count and term
//   bus   gray_counter_if.slave: en/up/load/load_bin in, gray/bin/term out
// Parameters:
//   WIDTH     counter width, 1..32
//   SATURATE  0 = wrap modulo 2^WIDTH, 1 = hold at the range end
module gray_counter #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic          clk,
   input  logic          rst,
   gray_counter_if.slave bus
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("gray_counter: WIDTH must be in 1..32");
   end

   if ($bits(bus.bin) != WIDTH) begin : g_bad_bus
      $error("gray_counter: interface WIDTH does not match counter WIDTH");
   end

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_term;

   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gray_nxt;
   logic             w_term_nxt;
   logic             w_at_max;
   logic             w_at_min;

   assign w_at_max = (r_bin == {WIDTH{1'b1}});
   assign w_at_min = (r_bin == {WIDTH{1'b0}});

   // Priority load > en; reset is handled in the register process.
   always_comb begin
      w_bin_nxt  = r_bin;
      w_term_nxt = 1'b0;
      if (bus.load) begin
         w_bin_nxt = bus.load_bin;
      end else if (bus.en) begin
         if (bus.up) begin
            if (w_at_max) begin
               w_term_nxt = 1'b1;
               if (SATURATE == 0) begin
                  w_bin_nxt = {WIDTH{1'b0}};
               end
            end else begin
               w_bin_nxt = r_bin + 1'b1;
            end
         end else begin
            if (w_at_min) begin
               w_term_nxt = 1'b1;
               if (SATURATE == 0) begin
                  w_bin_nxt = {WIDTH{1'b1}};
               end
            end else begin
               w_bin_nxt = r_bin - 1'b1;
            end
         end
      end
   end

   // Gray is computed from the next binary value so both registers load together.
   assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= {WIDTH{1'b0}};
         r_gray <= {WIDTH{1'b0}};
         r_term <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_gray_nxt;
         r_term <= w_term_nxt;
      end
   end

   assign bus.bin  = r_bin;
   assign bus.gray = r_gray;
   assign bus.term = r_term;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter
module tb_gray_counter;

   typedef struct {
      logic [31:0] bin;
      logic        term;
      logic        cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [4:0] load_bin = 5'd0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] g2b(input logic [31:0] g);
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   // Configurations: W=1..5 wrap, then W=4 and W=5 saturate.
   for (genvar g = 0; g < 7; g++) begin : cfg
      localparam int W = (g < 5) ? g + 1 : g - 1;
      localparam int S = (g >= 5) ? 1 : 0;
      localparam logic [31:0] MAX = (32'd1 << W) - 32'd1;

      gray_counter_if #(.WIDTH(W)) u_if ();

      assign u_if.en       = en;
      assign u_if.up       = up;
      assign u_if.load     = load;
      assign u_if.load_bin = load_bin[W-1:0];

      gray_counter #(.WIDTH(W), .SATURATE(S)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if.slave)
      );

      exp_t        q[$];
      logic [31:0] m_bin  = 32'd0;
      logic        m_term = 1'b0;

      // Reference model: predicts the state produced by this edge.
      always @(posedge clk) begin
         exp_t e;
         e.cnt = 1'b0;
         if (rst) begin
            m_bin  = 32'd0;
            m_term = 1'b0;
         end else if (load) begin
            m_bin  = {27'd0, load_bin} & MAX;
            m_term = 1'b0;
         end else if (en) begin
            e.cnt = 1'b1;
            if (up) begin
               if (m_bin == MAX) begin
                  m_term = 1'b1;
                  m_bin  = (S != 0) ? MAX : 32'd0;
               end else begin
                  m_term = 1'b0;
                  m_bin  = m_bin + 32'd1;
               end
            end else begin
               if (m_bin == 32'd0) begin
                  m_term = 1'b1;
                  m_bin  = (S != 0) ? 32'd0 : MAX;
               end else begin
                  m_term = 1'b0;
                  m_bin  = m_bin - 32'd1;
               end
            end
         end else begin
            m_term = 1'b0;
         end
         e.bin  = m_bin;
         e.term = m_term;
         q.push_back(e);
      end

      logic [31:0] prev_bin  = 32'd0;
      logic [31:0] prev_gray = 32'd0;
      logic        have_prev = 1'b0;

      always @(negedge clk) begin
         if (q.size() > 0) begin
            exp_t        e;
            logic [31:0] gb;
            logic [31:0] bb;
            e  = q.pop_front();
            gb = 32'(u_if.gray);
            bb = 32'(u_if.bin);
            chk($sformatf("w%0ds%0d_bin", W, S), bb, e.bin);
            chk($sformatf("w%0ds%0d_gray", W, S), gb, e.bin ^ (e.bin >> 1));
            chk($sformatf("w%0ds%0d_term", W, S), {31'd0, u_if.term}, {31'd0, e.term});
            chk($sformatf("w%0ds%0d_inv_g2b", W, S), g2b(gb), bb);
            chk($sformatf("w%0ds%0d_inv_par", W, S), {31'd0, ^gb}, {31'd0, bb[0]});
            if (e.cnt && have_prev && e.bin != prev_bin)
               chk($sformatf("w%0ds%0d_onebit", W, S), 32'($countones(gb ^ prev_gray)), 32'd1);
            prev_bin  = e.bin;
            prev_gray = gb;
            have_prev = 1'b1;
         end
      end
   end

   // Apply inputs for one edge, return at the following negedge.
   task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                      input logic [4:0] lb);
      rst      = r;
      en       = e;
      up       = u;
      load     = l;
      load_bin = lb;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      cyc(1, 0, 1, 0, 0);
      chk("rst_bin", 32'(cfg[3].u_if.bin), 32'd0);
      chk("rst_gray", 32'(cfg[3].u_if.gray), 32'd0);
      chk("rst_term", {31'd0, cfg[3].u_if.term}, 32'd0);

      // Sweep all widths across a full wrap
      for (int i = 0; i < 33; i++) cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("hold_term", {31'd0, cfg[4].u_if.term}, 32'd0);

      // Load
      cyc(0, 0, 1, 1, 5'b01010);
      chk("ld_bin", 32'(cfg[3].u_if.bin), 32'hA);
      chk("ld_gray", 32'(cfg[3].u_if.gray), 32'hF);
      chk("ld_term", {31'd0, cfg[3].u_if.term}, 32'd0);
      cyc(0, 1, 1, 1, 5'b00011);
      chk("ld_wins", 32'(cfg[3].u_if.bin), 32'h3);

      // Down-wrap from 0
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("dn_bin", 32'(cfg[3].u_if.bin), 32'hF);
      chk("dn_gray", 32'(cfg[3].u_if.gray), 32'h8);
      chk("dn_term", {31'd0, cfg[3].u_if.term}, 32'd1);
      cyc(0, 1, 0, 0, 0);
      chk("dn2_bin", 32'(cfg[3].u_if.bin), 32'hE);
      chk("dn2_gray", 32'(cfg[3].u_if.gray), 32'h9);
      chk("dn2_term", {31'd0, cfg[3].u_if.term}, 32'd0);

      // Saturate at the top
      cyc(0, 0, 1, 1, 5'b01111);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 0, 0);
         chk("sat_bin", 32'(cfg[5].u_if.bin), 32'hF);
         chk("sat_gray", 32'(cfg[5].u_if.gray), 32'h8);
         chk("sat_term", {31'd0, cfg[5].u_if.term}, 32'd1);
      end
      cyc(0, 1, 0, 0, 0);
      chk("sat_dn_bin", 32'(cfg[5].u_if.bin), 32'hE);
      chk("sat_dn_term", {31'd0, cfg[5].u_if.term}, 32'd0);

      // Reset mid-count overrides load and en
      cyc(1, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
      chk("mid_bin", 32'(cfg[3].u_if.bin), 32'h6);
      cyc(1, 1, 1, 1, 5'b10101);
      chk("mrst_bin", 32'(cfg[3].u_if.bin), 32'd0);
      chk("mrst_gray", 32'(cfg[3].u_if.gray), 32'd0);
      chk("mrst_term", {31'd0, cfg[3].u_if.term}, 32'd0);
      cyc(0, 1, 1, 0, 0);
      chk("resume_bin", 32'(cfg[3].u_if.bin), 32'd1);

      // Random traffic on every configuration
      for (int i = 0; i < 1000; i++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0),
             5'($urandom));
      end
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
